uart_string_tx: RTL and testbench
=================================

// Module: uart_string_tx
// PURPOSE
//  Consumer end of the byte-string source interface (i_next/o_data, NUL-terminated, source rewinds on next-at-NUL).
//  Pulls bytes from a string source and transmits each one as a UART 8N1 frame on o_tx.
//  On reaching the 0x00 terminator, advances the source once more so it rewinds, then reports done.
//  Sits between a string ROM and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  104  clocks per UART bit (12 MHz / 115200); must be >= 2
//  MAX_LEN       128  maximum bytes per message before forced stop (runaway guard); >= 1
// PORTS
//  i_clock    in   1  single clock; all state on posedge
//  i_reset_n  in   1  asynchronous, active-low reset
//  i_start    in   1  request one message; sampled only in IDLE
//  i_data     in   8  current source byte (combinational from source index)
//  o_next     out  1  one-cycle advance strobe to the source (source i_next)
//  o_tx       out  1  serial line; idle high
//  o_busy     out  1  high in every state except IDLE
//  o_done     out  1  one-cycle pulse: message finished
//  o_trunc    out  1  valid with o_done: 1 = stopped by MAX_LEN, not by terminator
// BEHAVIOUR
//  Reset values: o_tx=1, o_next=0, o_busy=0, o_done=0, o_trunc=0, state IDLE, counters 0. All outputs are registered.
//  States: IDLE, FETCH, START, DATA, STOP, REWIND.
//  - IDLE: if i_start=1 -> FETCH. byte_cnt cleared. o_done/o_trunc are high only in the first IDLE cycle after finishing.
//  - FETCH (1 cycle): sample i_data.
//      ==0x00                 -> REWIND.
//      !=0 and byte_cnt==MAX_LEN -> IDLE with o_done=1, o_trunc=1, no o_next.
//      else latch byte into shift reg, byte_cnt++, -> START.
//  - START: o_tx=0 for CLKS_PER_BIT clocks. o_next=1 during the first START cycle only, so the source advances on that edge.
//  - DATA: 8 bits, LSB first, each CLKS_PER_BIT clocks -> STOP.
//  - STOP: o_tx=1 for CLKS_PER_BIT clocks -> FETCH.
//  - REWIND (1 cycle): o_next=1 (source rewinds at NUL) -> IDLE with o_done=1, o_trunc=0.
//  Per byte: 1 FETCH + 10*CLKS_PER_BIT clocks. Gap between stop bit and next start bit is exactly 1 clock.
//  Exactly one o_next pulse per transmitted byte, plus one per terminator. o_next is never high in consecutive cycles.
//  i_start while busy: ignored. i_start held high: a new message begins on the cycle after the o_done cycle.
//  Empty string (first byte 0x00): no frame; o_tx stays 1; one o_next pulse; o_done.
//  Bit timer: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary. Bit index is 3 bits and wraps 7 -> STOP.
//  byte_cnt width: $clog2(MAX_LEN+1).
//  Reset mid-operation: o_tx immediately 1, state IDLE, no rewind pulse. The source is reset by the same i_reset_n.
// STRUCTURE
//  Shared package uart_pkg: state encoding localparams, default CLKS_PER_BIT, frame length constant (10 bits).
//  Sub-module uart_bit_timer (CLKS_PER_BIT): i_clock, i_reset_n, i_restart -> o_tick at end of each bit period.
//  The FSM, shift register and byte counter stay in uart_string_tx.
// TESTING  (CLKS_PER_BIT=4; cycle 0 = edge sampling i_start=1)
//  1. Reset asserted -> o_tx=1, o_next=0, o_busy=0, o_done=0, o_trunc=0, even with i_start=1 during reset.
//  2. Source "Hi\0" -> 0x48 frame on o_tx (bits 0,0,0,0,1,0,0,1,0,1 x4 clocks) from cycle 2, then 0x69 from cycle 43;
//     o_next high at cycles 2, 43, 84; o_done=1, o_trunc=0 at cycle 85 only.
//  3. Source "\0" -> o_tx constant 1; o_next at cycle 2; o_done at cycle 3.
//  4. "Hi\0" with i_start re-pulsed at cycle 20 -> waveform identical to test 2.
//  5. i_reset_n low at cycle 30 (mid 0x48 data bits) -> o_tx=1 and o_busy=0 within that cycle, no o_done;
//     after release, i_start re-sends "Hi" from the start.
//  6. MAX_LEN=3, source always 0x41 -> exactly 3 frames and 3 o_next pulses; o_done=1 with o_trunc=1; no rewind pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// UART string transmitter shared definitions.
// State encodings and framing constants.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_REWIND = 3'd5;

  localparam int CLKS_PER_BIT_DEF = 104;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// UART bit-period timer.
// Counts 0..CLKS_PER_BIT-1 and ticks on the last count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int W =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_restart || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_string_tx.sv
// Streams a NUL-terminated byte string out as UART 8N1 frames.
// Rewinds the source at the terminator, guards runaway strings.
module uart_string_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int MAX_LEN      = 128
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_next,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_trunc
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_d;
  logic          next_d;
  logic          done_d;
  logic          trunc_d;
  logic          tick;
  logic          restart;

  // Timer only runs while a frame is on the line.
  assign restart = (state_q == S_IDLE)
                || (state_q == S_FETCH)
                || (state_q == S_REWIND);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_restart(restart),
    .o_tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    next_d  = 1'b0;
    done_d  = 1'b0;
    trunc_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_data == 8'h00) begin
          state_d = S_REWIND;
          next_d  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          trunc_d = 1'b1;
        end else begin
          state_d = S_START;
          sh_d    = i_data;
          cnt_d   = cnt_q + CW'(1);
          idx_d   = '0;
          next_d  = 1'b1;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
          else sh_d = {1'b0, sh_q[7:1]};
        end
      end
      S_STOP: begin
        if (tick) state_d = S_FETCH;
      end
      S_REWIND: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered.
    unique case (1'b1)
      (state_d == S_START): tx_d = 1'b0;
      (state_d == S_DATA):  tx_d = sh_d[0];
      default:              tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      o_tx    <= 1'b1;
      o_next  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_trunc <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      o_tx    <= tx_d;
      o_next  <= next_d;
      o_busy  <= (state_d != S_IDLE);
      o_done  <= done_d;
      o_trunc <= trunc_d;
    end
  end

endmodule

// File: tb/tb_uart_string_tx.sv
// Scoreboard bench for uart_string_tx (CLKS_PER_BIT=4).
// Channel 0: string ROM source; channel 1: MAX_LEN=3, constant 'A'.
module tb_uart_string_tx;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } frm_t;

  typedef struct {
    int   cyc;
    logic tr;
  } done_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic [7:0] data_a;
  logic [7:0] data_b = 8'h41;
  logic next_a, tx_a, busy_a, done_a, trunc_a;
  logic next_b, tx_b, busy_b, done_b, trunc_b;

  logic [7:0] rom [0:7];
  int idx;
  int cyc = 0;
  int t0 [2] = '{0, 0};

  int n_checks = 0;
  int n_pass = 0;

  int    exp_next [2][$];
  frm_t  exp_frm  [2][$];
  done_t exp_done [2][$];

  logic        in_frm [2] = '{1'b0, 1'b0};
  int          fst    [2] = '{0, 0};
  int          off    [2] = '{0, 0};
  logic [39:0] samp   [2];
  logic        pnext  [2] = '{1'b0, 1'b0};

  uart_string_tx #(
    .CLKS_PER_BIT(4),
    .MAX_LEN     (128)
  ) dut_a (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_start  (start_a),
    .i_data   (data_a),
    .o_next   (next_a),
    .o_tx     (tx_a),
    .o_busy   (busy_a),
    .o_done   (done_a),
    .o_trunc  (trunc_a)
  );

  uart_string_tx #(
    .CLKS_PER_BIT(4),
    .MAX_LEN     (3)
  ) dut_b (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_start  (start_b),
    .i_data   (data_b),
    .o_next   (next_b),
    .o_tx     (tx_b),
    .o_busy   (busy_b),
    .o_done   (done_b),
    .o_trunc  (trunc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign data_a = rom[idx];

  // String source: advance on next, rewind when advanced at NUL.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= 0;
    else if (next_a) idx <= (rom[idx] == 8'h00) ? 0 : idx + 1;
  end

  task automatic check(string nm, logic [39:0] got,
                       logic [39:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, want);
  endtask

  function automatic logic [39:0] wave(logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] w;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) w[k] = f[k/4];
    return w;
  endfunction

  function automatic int pending(int ch);
    return exp_next[ch].size() + exp_frm[ch].size()
         + exp_done[ch].size();
  endfunction

  // Monitor: pops expectations as the DUTs present events.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      logic nx, tx, dn, tr;
      int   rel;
      nx  = (ch == 0) ? next_a  : next_b;
      tx  = (ch == 0) ? tx_a    : tx_b;
      dn  = (ch == 0) ? done_a  : done_b;
      tr  = (ch == 0) ? trunc_a : trunc_b;
      rel = cyc - t0[ch] + 1;
      if (!rst_n) begin
        in_frm[ch] = 1'b0;
        pnext[ch]  = 1'b0;
      end else begin
        if (nx) begin
          check("next_gap", 40'(pnext[ch]), 40'd0);
          check("next_avail", 40'(exp_next[ch].size() > 0),
                40'd1);
          if (exp_next[ch].size() > 0)
            check("next_cycle", 40'(rel),
                  40'(exp_next[ch].pop_front()));
        end
        pnext[ch] = nx;
        if (!in_frm[ch] && !tx) begin
          in_frm[ch] = 1'b1;
          fst[ch]    = rel;
          off[ch]    = 0;
        end
        if (in_frm[ch]) begin
          samp[ch][off[ch]] = tx;
          off[ch]++;
          if (off[ch] == 40) begin
            in_frm[ch] = 1'b0;
            check("frame_avail",
                  40'(exp_frm[ch].size() > 0), 40'd1);
            if (exp_frm[ch].size() > 0) begin
              frm_t f;
              f = exp_frm[ch].pop_front();
              check("frame_start", 40'(fst[ch]), 40'(f.cyc));
              check("frame_bits", samp[ch], wave(f.b));
            end
          end
        end
        if (dn) begin
          check("done_avail",
                40'(exp_done[ch].size() > 0), 40'd1);
          if (exp_done[ch].size() > 0) begin
            done_t d;
            d = exp_done[ch].pop_front();
            check("done_cycle", 40'(rel), 40'(d.cyc));
            check("trunc", 40'(tr), 40'(d.tr));
          end
        end
      end
    end
  end

  task automatic set_hi();
    rom[0] = 8'h48;
    rom[1] = 8'h69;
    rom[2] = 8'h00;
  endtask

  task automatic push_hi();
    exp_next[0].push_back(2);
    exp_next[0].push_back(43);
    exp_next[0].push_back(84);
    exp_frm[0].push_back('{2, 8'h48});
    exp_frm[0].push_back('{43, 8'h69});
    exp_done[0].push_back('{85, 1'b0});
  endtask

  task automatic pulse(int ch);
    @(negedge clk);
    if (ch == 0) start_a = 1'b1;
    else start_b = 1'b1;
    t0[ch] = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_rel(int ch, int c);
    int n = 0;
    while (cyc < t0[ch] + c && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(int ch, logic busy_chk);
    int n = 0;
    while (pending(ch) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 40'(pending(ch)), 40'd0);
    exp_next[ch].delete();
    exp_frm[ch].delete();
    exp_done[ch].delete();
    repeat (4) @(negedge clk);
    if (busy_chk)
      check("idle_busy",
            40'((ch == 0) ? busy_a : busy_b), 40'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    set_hi();
    rst_n   = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_a",    40'(tx_a),    40'd1);
    check("rst_next_a",  40'(next_a),  40'd0);
    check("rst_busy_a",  40'(busy_a),  40'd0);
    check("rst_done_a",  40'(done_a),  40'd0);
    check("rst_trunc_a", 40'(trunc_a), 40'd0);
    check("rst_tx_b",    40'(tx_b),    40'd1);
    check("rst_busy_b",  40'(busy_b),  40'd0);
    check("rst_next_b",  40'(next_b),  40'd0);
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_hi();
    pulse(0);
    wait_rel(0, 10);
    check("busy_mid", 40'(busy_a), 40'd1);
    drain(0, 1'b1);

    rom[0] = 8'h00;
    exp_next[0].push_back(2);
    exp_done[0].push_back('{3, 1'b0});
    pulse(0);
    drain(0, 1'b1);
    set_hi();

    push_hi();
    pulse(0);
    wait_rel(0, 19);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain(0, 1'b1);

    exp_next[0].push_back(2);
    pulse(0);
    wait_rel(0, 29);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx",   40'(tx_a),   40'd1);
    check("rst_mid_busy", 40'(busy_a), 40'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drain(0, 1'b0);
    push_hi();
    pulse(0);
    drain(0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      exp_next[1].push_back(2 + 41 * i);
      exp_frm[1].push_back('{2 + 41 * i, 8'h41});
    end
    exp_done[1].push_back('{125, 1'b1});
    pulse(1);
    drain(1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
